// File: rtl/sparc_memory_responder.sv
// Memory-side responder for the MPU MOV/MOC handshake: fixed-latency big-endian
// byte/half/word/doubleword accesses on an internal byte array.
module sparc_memory_responder #(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  Type,
    input  logic        SE,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        MisAlign
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [1:0]          type_q, type_d;
    logic                se_q, se_d;
    logic                mis_q, mis_d;
    logic [31:0]         dout_q, dout_d;
    logic                commit;
    logic                wr_en;
    logic [ADDR_W-1:0]   ea0, ea1, ea2, ea3;
    logic [31:0]         rdata;
    logic                unused_addr_hi;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    assign unused_addr_hi = ^Address[31:ADDR_W];

    function automatic logic misaligned(input logic [1:0] t, input logic [2:0] a);
        case (t)
            2'b01:   return a[0];
            2'b10:   return |a[1:0];
            2'b11:   return |a[2:0];
            default: return 1'b0;
        endcase
    endfunction

    // Beat 1 of a doubleword targets the next word; all byte lanes wrap in the array
    assign ea0 = addr_q + (beat_q ? ADDR_W'(4) : '0);
    assign ea1 = ea0 + ADDR_W'(1);
    assign ea2 = ea0 + ADDR_W'(2);
    assign ea3 = ea0 + ADDR_W'(3);

    always_comb begin
        rdata = {mem[ea0], mem[ea1], mem[ea2], mem[ea3]};
        case (type_q)
            2'b00:   rdata = {{24{se_q & mem[ea0][7]}}, mem[ea0]};
            2'b01:   rdata = {{16{se_q & mem[ea0][7]}}, mem[ea0], mem[ea1]};
            default: rdata = {mem[ea0], mem[ea1], mem[ea2], mem[ea3]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        type_d  = type_q;
        se_d    = se_q;
        mis_d   = mis_q;
        dout_d  = dout_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MOV) begin
                    addr_d  = Address[ADDR_W-1:0];
                    rw_d    = RW;
                    type_d  = Type;
                    se_d    = SE;
                    cnt_d   = CNT_LOAD;
                    beat_d  = 1'b0;
                    mis_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = S_ACK;
                    mis_d   = beat_q ? 1'b0 : misaligned(type_q, addr_q[2:0]);
                    if (rw_q && !mis_d) begin
                        dout_d = rdata;
                    end
                end
            end
            S_ACK: begin
                if (type_q == 2'b11 && !beat_q && !mis_q) begin
                    beat_d  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end else if (MOV) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            beat_q  <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            type_q  <= 2'b00;
            se_q    <= 1'b0;
            mis_q   <= 1'b0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            type_q  <= type_d;
            se_q    <= se_d;
            mis_q   <= mis_d;
            dout_q  <= dout_d;
        end
    end

    // Array is never cleared; a reset mid-operation leaves state in IDLE so no commit fires
    assign wr_en = commit && !rw_q && !mis_d;

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            case (type_q)
                2'b00: mem[ea0] <= DataIn[7:0];
                2'b01: begin
                    mem[ea0] <= DataIn[15:8];
                    mem[ea1] <= DataIn[7:0];
                end
                default: begin
                    mem[ea0] <= DataIn[31:24];
                    mem[ea1] <= DataIn[23:16];
                    mem[ea2] <= DataIn[15:8];
                    mem[ea3] <= DataIn[7:0];
                end
            endcase
        end
    end

    assign DataOut  = dout_q;
    assign MOC      = (state_q == S_ACK);
    assign MisAlign = (state_q == S_ACK) && mis_q;

endmodule

// File: tb/tb_sparc_memory_responder.sv
// Directed bench for sparc_memory_responder: vector table plus hand-written
// sequences for hold, doubleword, abort and reset behaviour.
module tb_sparc_memory_responder;

    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        MOV;
    logic        RW;
    logic [1:0]  Type;
    logic        SE;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        MisAlign;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rw;
        logic [1:0]  ty;
        logic        se;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] dout;
        logic        mis;
    } vec_t;

    vec_t vt[14];

    sparc_memory_responder #(.ADDR_W(9), .LATENCY(LAT)) dut (
        .Clk(Clk), .Clr(Clr), .MOV(MOV), .RW(RW), .Type(Type), .SE(SE),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC),
        .MisAlign(MisAlign)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_moc(output int n);
        n = 0;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (!MOC && n < 40);
    endtask

    task automatic cycles_no_moc(input string name, input int k);
        int seen;
        seen = 0;
        for (int j = 0; j < k; j++) begin
            @(posedge Clk); #1;
            if (MOC) seen++;
        end
        chk(name, seen, 0);
    endtask

    task automatic op(input string name, input logic rw, input logic [1:0] ty, input logic se,
                      input logic [31:0] addr, input logic [31:0] din,
                      input logic [31:0] exp_dout, input logic exp_mis);
        int n;
        MOV = 1'b1; RW = rw; Type = ty; SE = se; Address = addr; DataIn = din;
        wait_moc(n);
        chk({name, " latency"}, n, LAT + 1);
        chk({name, " misalign"}, {31'd0, MisAlign}, {31'd0, exp_mis});
        chk({name, " dataout"}, DataOut, exp_dout);
        MOV = 1'b0;
        @(posedge Clk); #1;
    endtask

    initial begin
        int n;
        vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
        vt[1]  = '{1'b1, 2'b00, 1'b0, 32'h10,  32'h0,        32'h000000DE, 1'b0};
        vt[2]  = '{1'b1, 2'b00, 1'b1, 32'h13,  32'h0,        32'hFFFFFFEF, 1'b0};
        vt[3]  = '{1'b1, 2'b01, 1'b1, 32'h12,  32'h0,        32'hFFFFBEEF, 1'b0};
        vt[4]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vt[5]  = '{1'b1, 2'b01, 1'b0, 32'h10,  32'h0,        32'h0000DEAD, 1'b0};
        vt[6]  = '{1'b1, 2'b00, 1'b1, 32'h11,  32'h0,        32'hFFFFFFAD, 1'b0};
        vt[7]  = '{1'b0, 2'b00, 1'b0, 32'h11,  32'hFFFFFF7F, 32'hFFFFFFAD, 1'b0};
        vt[8]  = '{1'b0, 2'b01, 1'b0, 32'h12,  32'hABCD1234, 32'hFFFFFFAD, 1'b0};
        vt[9]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDE7F1234, 1'b0};
        vt[10] = '{1'b1, 2'b01, 1'b1, 32'h11,  32'h0,        32'hDE7F1234, 1'b1};
        vt[11] = '{1'b1, 2'b10, 1'b0, 32'h210, 32'h0,        32'hDE7F1234, 1'b0};
        vt[12] = '{1'b1, 2'b00, 1'b1, 32'h12,  32'h0,        32'h00000012, 1'b0};
        vt[13] = '{1'b1, 2'b01, 1'b0, 32'h12,  32'h0,        32'h00001234, 1'b0};

        Clr = 1'b1; MOV = 1'b0; RW = 1'b0; Type = 2'b00; SE = 1'b0;
        Address = 32'd0; DataIn = 32'd0;
        #12;
        chk("reset DataOut", DataOut, 32'd0);
        chk("reset MOC", {31'd0, MOC}, 32'd0);
        chk("reset MisAlign", {31'd0, MisAlign}, 32'd0);
        Clr = 1'b0;
        @(posedge Clk); #1;

        for (int i = 0; i < 14; i++) begin
            op($sformatf("vec%0d", i), vt[i].rw, vt[i].ty, vt[i].se, vt[i].addr,
               vt[i].din, vt[i].dout, vt[i].mis);
        end

        // MOC exactly one cycle after E2, none while MOV is held
        MOV = 1'b1; RW = 1'b1; Type = 2'b10; SE = 1'b0; Address = 32'h10;
        for (int k = 1; k <= 3; k++) begin
            @(posedge Clk); #1;
            chk($sformatf("timing MOC edge%0d", k - 1), {31'd0, MOC}, {31'd0, (k == 3)});
        end
        chk("timing dataout", DataOut, 32'hDE7F1234);
        for (int k = 0; k < 4; k++) begin
            @(posedge Clk); #1;
            chk($sformatf("hold MOC %0d", k), {31'd0, MOC}, 32'd0);
        end
        MOV = 1'b0;
        @(posedge Clk); #1;
        chk("hold release MOC", {31'd0, MOC}, 32'd0);

        // Doubleword write, DataIn switched for beat 1
        MOV = 1'b1; RW = 1'b0; Type = 2'b11; Address = 32'h20; DataIn = 32'h11111111;
        wait_moc(n);
        chk("dw wr beat0 latency", n, LAT + 1);
        chk("dw wr beat0 misalign", {31'd0, MisAlign}, 32'd0);
        DataIn = 32'h22222222;
        wait_moc(n);
        chk("dw wr beat1 latency", n, LAT + 1);
        MOV = 1'b0;
        @(posedge Clk); #1;
        op("rd w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
        op("rd w24", 1'b1, 2'b10, 1'b0, 32'h24, 32'h0, 32'h22222222, 1'b0);

        // Doubleword read
        MOV = 1'b1; RW = 1'b1; Type = 2'b11; Address = 32'h20;
        wait_moc(n);
        chk("dw rd beat0 latency", n, LAT + 1);
        chk("dw rd beat0 data", DataOut, 32'h11111111);
        wait_moc(n);
        chk("dw rd beat1 latency", n, LAT + 1);
        chk("dw rd beat1 data", DataOut, 32'h22222222);
        MOV = 1'b0;
        @(posedge Clk); #1;

        // Misaligned accesses
        op("mis wr w22", 1'b0, 2'b10, 1'b0, 32'h22, 32'h12345678, 32'h22222222, 1'b1);
        op("after mis w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
        op("after mis w24", 1'b1, 2'b10, 1'b0, 32'h24, 32'h0, 32'h22222222, 1'b0);
        MOV = 1'b1; RW = 1'b1; Type = 2'b11; Address = 32'h24;
        wait_moc(n);
        chk("mis dw latency", n, LAT + 1);
        chk("mis dw misalign", {31'd0, MisAlign}, 32'd1);
        cycles_no_moc("mis dw single beat", 6);
        MOV = 1'b0;
        @(posedge Clk); #1;
        chk("misalign low when idle", {31'd0, MisAlign}, 32'd0);

        // Reset during WAIT aborts the write
        op("wr w30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0BADC0DE, 32'h22222222, 1'b0);
        MOV = 1'b1; RW = 1'b0; Type = 2'b10; Address = 32'h30; DataIn = 32'hCAFEF00D;
        @(posedge Clk); #1;
        Clr = 1'b1;
        #1;
        chk("clr DataOut", DataOut, 32'd0);
        chk("clr MOC", {31'd0, MOC}, 32'd0);
        MOV = 1'b0;
        #1;
        Clr = 1'b0;
        cycles_no_moc("clr no MOC", 4);
        op("after clr w30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0BADC0DE, 1'b0);

        // MOV dropped during WAIT aborts the write
        op("wr b40", 1'b0, 2'b00, 1'b0, 32'h40, 32'h00000055, 32'h0BADC0DE, 1'b0);
        MOV = 1'b1; RW = 1'b0; Type = 2'b00; Address = 32'h40; DataIn = 32'h000000AA;
        @(posedge Clk); #1;
        MOV = 1'b0;
        cycles_no_moc("abort no MOC", 5);
        op("after abort b40", 1'b1, 2'b00, 1'b0, 32'h40, 32'h0, 32'h00000055, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
